// File: rtl/config_pkg.sv
// Shared constants, opcode/state enums and address helpers for the
// config-menu tile buffer writer.
package config_pkg;

  localparam int CFG_COLS      = 40;
  localparam int CFG_ROWS      = 23;
  localparam int CFG_BUF_DEPTH = CFG_COLS * CFG_ROWS;

  // Narrow forms of the limits so comparisons against ports stay width-matched.
  localparam logic [4:0] CFG_ROW_LIMIT = 5'(CFG_ROWS);
  localparam logic [6:0] CFG_COL_LIMIT = 7'(CFG_COLS);
  localparam logic [9:0] CFG_LAST_ADDR = 10'(CFG_BUF_DEPTH - 1);

  localparam logic [7:0] CFG_DIGIT_BASE = 8'h30;
  localparam logic [7:0] CFG_BLANK_TILE = 8'h20;

  typedef enum logic [1:0] {
    CFG_OP_CHAR  = 2'd0,
    CFG_OP_NUM   = 2'd1,
    CFG_OP_CLEAR = 2'd2,
    CFG_OP_RSVD  = 2'd3
  } cfg_op_t;

  typedef enum logic [1:0] {
    CFG_ST_IDLE    = 2'd0,
    CFG_ST_CONVERT = 2'd1,
    CFG_ST_EMIT    = 2'd2,
    CFG_ST_CLEAR   = 2'd3
  } cfg_state_t;

  // row*40+col built from shifts so no multiplier is needed.
  function automatic logic [9:0] cfg_addr(input logic [4:0] row, input logic [5:0] col);
    logic [9:0] r;
    r = {5'd0, row};
    return (r << 5) + (r << 3) + {4'd0, col};
  endfunction

  // Digit count: 0 means one digit, anything above five is five.
  function automatic logic [2:0] cfg_clamp_width(input logic [2:0] w);
    if (w == 3'd0) return 3'd1;
    else if (w > 3'd5) return 3'd5;
    else return w;
  endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// 16-bit binary to 5-digit BCD using shift-add-3, one bit per cycle.
// start_i loads the operand; the next 16 edges each perform one step.
// done_o is high during the cycle whose closing edge performs the final
// step, so bcd_o holds the finished result from that edge onward.
module bin_to_bcd (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic [19:0] bcd_o,
  output logic        done_o
);

  logic [15:0] bin_q;
  logic [19:0] bcd_q;
  logic [3:0]  cnt_q;
  logic        run_q;
  logic [19:0] adj;

  // Add 3 to every digit that is 5 or more before the next shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // Load on start, then shift one binary bit into the BCD field per cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      bin_q <= bin_i;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      {bcd_q, bin_q} <= {adj, bin_q} << 1;
      cnt_q          <= cnt_q + 4'd1;
      if (cnt_q == 4'd15) run_q <= 1'b0;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = run_q && (cnt_q == 4'd15);

endmodule

// File: rtl/config_buffer_writer.sv
// Expands single config-controller commands (place tile, render decimal
// number, clear buffer) into a stream of one-per-cycle tile-buffer writes.
//
// Handshake: a command transfers on a rising edge where cmd_valid_in and
// cmd_ready_out are both high; all cmd_* fields are captured on that edge.
// cmd_ready_out is a register that is high exactly when the FSM is in IDLE
// (and low for the first cycle after reset release).
module config_buffer_writer
  import config_pkg::*;
#(
  parameter logic [7:0] DIGIT_BASE = CFG_DIGIT_BASE,
  parameter logic [7:0] BLANK_TILE = CFG_BLANK_TILE
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [1:0]  cmd_op_in,
  input  logic [4:0]  cmd_row_in,
  input  logic [5:0]  cmd_col_in,
  input  logic [15:0] cmd_data_in,
  input  logic [2:0]  cmd_width_in,
  input  logic        cmd_zero_pad_in,
  output logic        buf_write_valid_out,
  output logic [9:0]  buf_write_addr_out,
  output logic [7:0]  buf_write_data_out,
  output logic        busy_out
);

  cfg_state_t  state_q;
  logic        ready_q;
  logic        busy_q;
  logic        wr_valid_q;
  logic [9:0]  wr_addr_q;
  logic [7:0]  wr_data_q;

  logic [4:0]  row_q;
  logic [5:0]  col_q;
  logic [7:0]  tile_q;
  logic [2:0]  width_q;
  logic        pad_q;
  logic [2:0]  emit_idx_q;
  logic        seen_nz_q;
  logic [9:0]  clr_addr_q;

  logic        accept_d;
  logic        bcd_start_d;
  logic        bcd_done;
  logic [19:0] bcd_w;
  logic        char_in_range_d;
  logic [2:0]  digit_idx_d;
  logic [3:0]  digit_d;
  logic [6:0]  emit_col_d;
  logic        emit_in_range_d;
  logic        emit_blank_d;
  logic [7:0]  emit_tile_d;
  logic        emit_last_d;

  assign accept_d        = cmd_valid_in && ready_q && (state_q == CFG_ST_IDLE);
  assign bcd_start_d     = accept_d && (cfg_op_t'(cmd_op_in) == CFG_OP_NUM);
  assign char_in_range_d = (cmd_row_in < CFG_ROW_LIMIT) && ({1'b0, cmd_col_in} < CFG_COL_LIMIT);

  bin_to_bcd u_bcd (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .start_i (bcd_start_d),
    .bin_i   (cmd_data_in),
    .bcd_o   (bcd_w),
    .done_o  (bcd_done)
  );

  // Select the digit for the current emit slot (most significant first) and
  // decide its tile, its column and whether it falls outside the buffer.
  always_comb begin
    digit_idx_d = width_q - 3'd1 - emit_idx_q;
    case (digit_idx_d)
      3'd0:    digit_d = bcd_w[3:0];
      3'd1:    digit_d = bcd_w[7:4];
      3'd2:    digit_d = bcd_w[11:8];
      3'd3:    digit_d = bcd_w[15:12];
      3'd4:    digit_d = bcd_w[19:16];
      default: digit_d = 4'd0;
    endcase
    emit_col_d      = {1'b0, col_q} + {4'd0, emit_idx_q};
    emit_in_range_d = (row_q < CFG_ROW_LIMIT) && (emit_col_d < CFG_COL_LIMIT);
    // The units digit is never blanked so a zero value still shows '0'.
    emit_blank_d    = !pad_q && !seen_nz_q && (digit_d == 4'd0) && (digit_idx_d != 3'd0);
    emit_tile_d     = emit_blank_d ? BLANK_TILE : (DIGIT_BASE + {4'd0, digit_d});
    emit_last_d     = (emit_idx_q == (width_q - 3'd1));
  end

  // Command FSM with registered write port, ready and busy outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= CFG_ST_IDLE;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      tile_q     <= '0;
      width_q    <= 3'd1;
      pad_q      <= 1'b0;
      emit_idx_q <= '0;
      seen_nz_q  <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      case (state_q)
        CFG_ST_IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (accept_d) begin
            row_q   <= cmd_row_in;
            col_q   <= cmd_col_in;
            tile_q  <= cmd_data_in[7:0];
            width_q <= cfg_clamp_width(cmd_width_in);
            pad_q   <= cmd_zero_pad_in;
            case (cfg_op_t'(cmd_op_in))
              CFG_OP_CHAR: begin
                if (char_in_range_d) begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= cfg_addr(cmd_row_in, cmd_col_in);
                  wr_data_q  <= cmd_data_in[7:0];
                end
              end
              CFG_OP_NUM: begin
                state_q <= CFG_ST_CONVERT;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
              CFG_OP_CLEAR: begin
                state_q    <= CFG_ST_CLEAR;
                ready_q    <= 1'b0;
                busy_q     <= 1'b1;
                clr_addr_q <= '0;
              end
              default: begin
              end
            endcase
          end
        end

        CFG_ST_CONVERT: begin
          if (bcd_done) begin
            state_q    <= CFG_ST_EMIT;
            emit_idx_q <= '0;
            seen_nz_q  <= 1'b0;
          end
        end

        CFG_ST_EMIT: begin
          // Off-buffer digits still consume their cycle, keeping spacing fixed.
          if (emit_in_range_d) begin
            wr_valid_q <= 1'b1;
            wr_addr_q  <= cfg_addr(row_q, emit_col_d[5:0]);
            wr_data_q  <= emit_tile_d;
          end
          if (digit_d != 4'd0) seen_nz_q <= 1'b1;
          if (emit_last_d) begin
            state_q <= CFG_ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            emit_idx_q <= emit_idx_q + 3'd1;
          end
        end

        CFG_ST_CLEAR: begin
          wr_valid_q <= 1'b1;
          wr_addr_q  <= clr_addr_q;
          wr_data_q  <= tile_q;
          clr_addr_q <= clr_addr_q + 10'd1;
          if (clr_addr_q == CFG_LAST_ADDR) begin
            state_q <= CFG_ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= CFG_ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_out       = ready_q;
  assign busy_out            = busy_q;
  assign buf_write_valid_out = wr_valid_q;
  assign buf_write_addr_out  = wr_addr_q;
  assign buf_write_data_out  = wr_data_q;

endmodule
